// File: rtl/musb_uart_rx.sv
// UART receiver: 8 data bits LSB first, 1 stop bit, one-entry output register with ready/ack.
// Define MUSB_UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module musb_uart_rx #(
  parameter int unsigned BUS_FREQ = 100,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_overrun,
  output logic       rx_frame_error,
  output logic       rx_parity_error
);

  localparam int unsigned DIVISOR = (BUS_FREQ * 1000000) / BAUD;
  localparam int unsigned HALF    = DIVISOR / 2;
  localparam int unsigned CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  generate
    if (DIVISOR < 4) begin : g_bad_divisor
      $error("musb_uart_rx: BUS_FREQ*1e6/BAUD must be at least 4");
    end
  endgenerate

`ifdef MUSB_UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_armed, w_armed_nxt;
  logic [7:0]       w_data_nxt;
  logic             w_ready_nxt, w_ovr_nxt, w_ferr_nxt, w_byte_ok;
  logic             w_rxs, w_tick;
`ifdef MUSB_UART_RX_PARITY_EN
  logic             r_par, w_par_nxt, w_perr_nxt;
`endif

  assign w_rxs  = r_sync[1];
  assign w_tick = (r_cnt == CNT_W'(DIVISOR - 1));

  // Next-state, frame decoding and the output handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_armed_nxt = r_armed;
    w_data_nxt  = rx_data;
    w_ready_nxt = rx_ready;
    w_ovr_nxt   = rx_overrun;
    w_ferr_nxt  = 1'b0;
    w_byte_ok   = 1'b0;
`ifdef MUSB_UART_RX_PARITY_EN
    w_par_nxt   = r_par;
    w_perr_nxt  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rxs) w_armed_nxt = 1'b1;
        else if (r_armed) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == CNT_W'(HALF - 1)) begin
          w_cnt_nxt = '0;
          w_idx_nxt = '0;
          w_state_nxt = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rxs, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
`ifdef MUSB_UART_RX_PARITY_EN
          if (r_idx == 3'd7) w_state_nxt = S_PARITY;
`else
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef MUSB_UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_par_nxt   = w_rxs;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          w_armed_nxt = 1'b0;
          if (!w_rxs) w_ferr_nxt = 1'b1;
`ifdef MUSB_UART_RX_PARITY_EN
          else if (^{r_shift, r_par}) w_perr_nxt = 1'b1;
`endif
          else w_byte_ok = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A same-cycle ack frees the slot, so a new byte replaces the old one.
    if (w_byte_ok) begin
      if (!rx_ready || rx_ack) begin
        w_data_nxt  = w_shift_nxt;
        w_ready_nxt = 1'b1;
        w_ovr_nxt   = 1'b0;
      end else begin
        w_ovr_nxt = 1'b1;
      end
    end else if (rx_ready && rx_ack) begin
      w_ready_nxt = 1'b0;
      w_ovr_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync         <= 2'b11;
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_shift        <= '0;
      r_armed        <= 1'b0;
      rx_data        <= '0;
      rx_ready       <= 1'b0;
      rx_overrun     <= 1'b0;
      rx_frame_error <= 1'b0;
    end else begin
      r_sync         <= {r_sync[0], uart_rx};
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_idx          <= w_idx_nxt;
      r_shift        <= w_shift_nxt;
      r_armed        <= w_armed_nxt;
      rx_data        <= w_data_nxt;
      rx_ready       <= w_ready_nxt;
      rx_overrun     <= w_ovr_nxt;
      rx_frame_error <= w_ferr_nxt;
    end
  end

`ifdef MUSB_UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par           <= 1'b0;
      rx_parity_error <= 1'b0;
    end else begin
      r_par           <= w_par_nxt;
      rx_parity_error <= w_perr_nxt;
    end
  end
`else
  assign rx_parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_musb_uart_rx.sv
// Scoreboard bench for musb_uart_rx at DIVISOR=8: directed scenarios plus random frames.
// Build with MUSB_UART_RX_PARITY_EN defined to exercise the parity variant.
module tb_musb_uart_rx;

  localparam int unsigned DIV = 8;
`ifdef MUSB_UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int unsigned LAT = 2 + DIV / 2 + 9 * DIV + 1 + (PAR ? DIV : 0);
  localparam int K_LOAD = 0, K_OVR = 1, K_FERR = 2, K_PERR = 3;

  typedef struct {
    int          kind;
    logic [7:0]  data;
    int unsigned cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready, rx_overrun, rx_frame_error, rx_parity_error;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  ev_t         q[$];

  // Reference model of the consumer-visible state.
  bit         m_ready = 1'b0;
  bit         m_ovr = 1'b0;
  logic [7:0] m_data = 8'h00;

  bit p_ready = 1'b0, p_ack = 1'b0, p_ovr = 1'b0;

  musb_uart_rx #(.BUS_FREQ(1), .BAUD(125000)) dut (
    .clk             (clk),
    .rst             (rst),
    .uart_rx         (uart_rx),
    .rx_ack          (rx_ack),
    .rx_data         (rx_data),
    .rx_ready        (rx_ready),
    .rx_overrun      (rx_overrun),
    .rx_frame_error  (rx_frame_error),
    .rx_parity_error (rx_parity_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_event(input int k);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", k, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || (k == K_LOAD && rx_data !== e.data)) begin
        errors++;
        $display("FAIL event: got kind %0d data %0h expected kind %0d data %0h", k, rx_data, e.kind, e.data);
      end
      checks++;
      if (cyc > e.cyc + 1 || cyc + 1 < e.cyc) begin
        errors++;
        $display("FAIL latency: got cycle %0d expected %0d +/-1", cyc, e.cyc);
      end
    end
  endtask

  // Monitor: turns DUT output activity into events and checks them against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_frame_error) mon_event(K_FERR);
      if (rx_parity_error) mon_event(K_PERR);
      if (rx_overrun && !p_ovr) mon_event(K_OVR);
      if (rx_ready && (!p_ready || p_ack)) mon_event(K_LOAD);
    end
    p_ready = rx_ready;
    p_ack   = rx_ack;
    p_ovr   = rx_overrun;
  end

  // Drives one frame onto the line; the line is left at the stop-bit level.
  task automatic send_bits(input logic [7:0] b, input bit stop, input bit pbit, output int unsigned t0);
    @(posedge clk); #1 uart_rx = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(posedge clk);
      #1 uart_rx = b[i];
    end
    if (PAR) begin
      repeat (DIV) @(posedge clk);
      #1 uart_rx = pbit;
    end
    repeat (DIV) @(posedge clk);
    #1 uart_rx = stop;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  // Predicts the frame's outcome from the frame rules, then transmits it.
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit pbit, input bit ack_del);
    ev_t         e;
    int unsigned t0;
    bit          push;
    push   = 1'b1;
    e.data = b;
    e.cyc  = 0;
    if (!stop) e.kind = K_FERR;
    else if (PAR && ((^b) ^ pbit)) e.kind = K_PERR;
    else if (m_ready && !ack_del) begin
      e.kind = K_OVR;
      push   = !m_ovr;
      m_ovr  = 1'b1;
    end else begin
      e.kind  = K_LOAD;
      m_ready = 1'b1;
      m_ovr   = 1'b0;
      m_data  = b;
    end
    fork
      send_bits(b, stop, pbit, t0);
      begin
        @(posedge clk); #1;
        e.cyc = cyc + LAT;
        if (push) q.push_back(e);
        if (ack_del) begin
          repeat (LAT - 2) @(posedge clk);
          #1 rx_ack = 1'b1;
          @(posedge clk);
          #1 rx_ack = 1'b0;
        end
      end
    join
  endtask

  task automatic do_ack();
    @(posedge clk); #1 rx_ack = 1'b1;
    @(posedge clk); #1 rx_ack = 1'b0;
    if (m_ready) begin
      m_ready = 1'b0;
      m_ovr   = 1'b0;
    end
    chk("ack_ready", 32'(rx_ready), 32'(m_ready));
    chk("ack_overrun", 32'(rx_overrun), 32'(m_ovr));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned t0;
    logic [7:0]  b;
    bit          st, pb;

    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_data", 32'(rx_data), 32'h00);
    chk("rst_ready", 32'(rx_ready), 32'h0);
    chk("rst_overrun", 32'(rx_overrun), 32'h0);
    chk("rst_ferr", 32'(rx_frame_error), 32'h0);
    chk("rst_perr", 32'(rx_parity_error), 32'h0);
    idle(5);

    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0);
    idle(3);
    chk("a5_data", 32'(rx_data), 32'hA5);
    do_ack();

    send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0);
    send_frame(8'hC3, 1'b1, ^8'hC3, 1'b0);
    idle(3);
    chk("ovr_data", 32'(rx_data), 32'h3C);
    chk("ovr_flag", 32'(rx_overrun), 32'h1);
    do_ack();

    send_frame(8'h11, 1'b1, ^8'h11, 1'b0);
    idle(2);
    send_frame(8'h55, 1'b1, ^8'h55, 1'b1);
    idle(3);
    chk("ackdel_data", 32'(rx_data), 32'h55);
    chk("ackdel_ready", 32'(rx_ready), 32'h1);
    chk("ackdel_ovr", 32'(rx_overrun), 32'h0);
    do_ack();

    send_frame(8'h96, 1'b0, ^8'h96, 1'b0);
    idle(40);
    chk("break_ready", 32'(rx_ready), 32'h0);
    uart_rx = 1'b1;
    idle(5);
    send_frame(8'h7E, 1'b1, ^8'h7E, 1'b0);
    idle(3);
    chk("after_break_data", 32'(rx_data), 32'h7E);

    @(posedge clk); #1 uart_rx = 1'b0;
    idle(2);
    uart_rx = 1'b1;
    idle(30);
    chk("glitch_data", 32'(rx_data), 32'(m_data));
    chk("glitch_ready", 32'(rx_ready), 32'(m_ready));

    fork
      send_bits(8'hFF, 1'b1, 1'b0, t0);
      begin
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    m_data  = 8'h00;
    idle(5);
    chk("midrst_data", 32'(rx_data), 32'h00);
    chk("midrst_ready", 32'(rx_ready), 32'h0);
    chk("midrst_ovr", 32'(rx_overrun), 32'h0);
    send_frame(8'h01, 1'b1, ^8'h01, 1'b0);
    idle(3);
    chk("post_rst_data", 32'(rx_data), 32'h01);
    do_ack();

    if (PAR) begin
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      idle(3);
      chk("par_ok_data", 32'(rx_data), 32'h07);
      do_ack();
      send_frame(8'h07, 1'b1, 1'b0, 1'b0);
      idle(3);
      chk("par_bad_ready", 32'(rx_ready), 32'h0);
    end

    for (int i = 0; i < 24; i++) begin
      b  = 8'($urandom);
      st = ($urandom_range(0, 5) != 0);
      pb = (^b) ^ ($urandom_range(0, 4) == 0);
      send_frame(b, st, pb, 1'b0);
      uart_rx = 1'b1;
      idle($urandom_range(3, 20));
      chk("rand_data", 32'(rx_data), 32'(m_data));
      if ($urandom_range(0, 2) != 0) do_ack();
    end

    for (int i = 0; i < 300 && q.size() != 0; i++) idle(1);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending events expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
